// File: rtl/text_buffer_writer.sv
// Character screen buffer: decodes a byte stream into a COLS x ROWS glyph RAM and answers per-pixel lookups.
// Latency: an accepted byte is fully processed in its accept cycle; ascii_code is valid one cycle after x/y.
// Backpressure: char_ready is low (busy high) for the whole of every clear sweep: init, row clear, full clear.
module text_buffer_writer #(
    parameter int         X0    = 192,
    parameter int         Y0    = 208,
    parameter int         COLS  = 32,
    parameter int         ROWS  = 4,
    parameter logic [7:0] BLANK = 8'h20
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [7:0]                char_in,
    input  logic                      char_valid,
    output logic                      char_ready,
    input  logic [9:0]                x,
    input  logic [9:0]                y,
    output logic [7:0]                ascii_code,
    output logic [$clog2(COLS)-1:0]   cursor_col,
    output logic [$clog2(ROWS)-1:0]   cursor_row,
    output logic                      busy
);

    localparam int CW    = $clog2(COLS);
    localparam int RW    = $clog2(ROWS);
    localparam int AW    = CW + RW;
    localparam int CELLS = COLS * ROWS;

    localparam logic [CW-1:0] COL_MAX  = CW'(COLS - 1);
    localparam logic [AW-1:0] ROW_LAST = AW'(COLS - 1);
    localparam logic [AW-1:0] ADDR_MAX = AW'(CELLS - 1);

    // Window edges widened to 11 bits so X0+8*COLS never overflows the compare.
    localparam logic [10:0] X_LO = 11'(X0);
    localparam logic [10:0] X_HI = 11'(X0 + 8 * COLS);
    localparam logic [10:0] Y_LO = 11'(Y0);
    localparam logic [10:0] Y_HI = 11'(Y0 + 16 * ROWS);

    typedef enum logic [1:0] {
        S_INIT,
        S_IDLE,
        S_CLR_ROW,
        S_CLR_ALL
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   col, col_nxt;
    logic [RW-1:0]   row, row_nxt;
    logic [AW-1:0]   cnt, cnt_nxt;

    logic            we;
    logic [AW-1:0]   waddr;
    logic [7:0]      wdata;

    logic [7:0]      mem [CELLS];

    logic            in_win;
    logic [CW-1:0]   rcol;
    logic [RW-1:0]   rrow;
    logic            printable;

    assign char_ready = (state == S_IDLE);
    assign busy       = (state != S_IDLE);
    assign cursor_col = col;
    assign cursor_row = row;

    assign printable  = char_in[7] || ((char_in >= 8'h20) && (char_in <= 8'h7E));

    // Next-state, cursor update and single write-port request.
    always_comb begin
        state_nxt = state;
        col_nxt   = col;
        row_nxt   = row;
        cnt_nxt   = cnt;
        we        = 1'b0;
        waddr     = '0;
        wdata     = BLANK;

        case (state)
            S_INIT, S_CLR_ALL: begin
                we    = 1'b1;
                waddr = cnt;
                if (cnt == ADDR_MAX) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + AW'(1);
                end
            end

            S_CLR_ROW: begin
                we    = 1'b1;
                waddr = {row, cnt[CW-1:0]};
                if (cnt == ROW_LAST) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + AW'(1);
                end
            end

            default: begin
                if (char_valid) begin
                    if (printable) begin
                        we    = 1'b1;
                        waddr = {row, col};
                        wdata = char_in;
                        if (col != COL_MAX) begin
                            col_nxt = col + CW'(1);
                        end else begin
                            // Row wrap: the new row is blanked before more input is taken.
                            col_nxt   = '0;
                            row_nxt   = row + RW'(1);
                            cnt_nxt   = '0;
                            state_nxt = S_CLR_ROW;
                        end
                    end else if (char_in == 8'h0D || char_in == 8'h0A) begin
                        col_nxt   = '0;
                        row_nxt   = row + RW'(1);
                        cnt_nxt   = '0;
                        state_nxt = S_CLR_ROW;
                    end else if (char_in == 8'h08) begin
                        if (col != '0) begin
                            col_nxt = col - CW'(1);
                            we      = 1'b1;
                            waddr   = {row, col - CW'(1)};
                        end else if (row != '0) begin
                            row_nxt = row - RW'(1);
                            col_nxt = COL_MAX;
                            we      = 1'b1;
                            waddr   = {row - RW'(1), COL_MAX};
                        end
                    end else if (char_in == 8'h0C) begin
                        col_nxt   = '0;
                        row_nxt   = '0;
                        cnt_nxt   = '0;
                        state_nxt = S_CLR_ALL;
                    end
                    // Remaining control codes are consumed without effect.
                end
            end
        endcase
    end

    // State and cursor registers; reset restarts the init sweep.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_INIT;
            col   <= '0;
            row   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            col   <= col_nxt;
            row   <= row_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Cell RAM write port; suppressed while reset is asserted.
    always_ff @(posedge clk) begin
        if (rst_n && we) begin
            mem[waddr] <= wdata;
        end
    end

    // Beam-to-cell mapping; col/row are only meaningful inside the window.
    always_comb begin
        in_win = ({1'b0, x} >= X_LO) && ({1'b0, x} < X_HI) &&
                 ({1'b0, y} >= Y_LO) && ({1'b0, y} < Y_HI);
        rcol   = CW'((x - 10'(X0)) >> 3);
        rrow   = RW'((y - 10'(Y0)) >> 4);
    end

    // Registered glyph lookup; reads see the pre-write value on a same-cell collision.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ascii_code <= 8'h00;
        end else if (in_win) begin
            ascii_code <= mem[{rrow, rcol}];
        end else begin
            ascii_code <= 8'h00;
        end
    end

endmodule

// File: doc/text_buffer_writer.md
Name: text_buffer_writer

Overview:
- Character screen buffer that feeds the VGA text renderer's `ascii_code` input.
- Accepts a byte stream over a valid/ready handshake, typically from a UART or keyboard front-end. Bytes with bit7=1 are Thai glyph codes; bytes with bit7=0 are ASCII.
- Stores glyph codes in a COLS x ROWS cell RAM and handles cursor, backspace, newline and clear-screen.
- Answers per-pixel (x, y) lookups with the glyph code of the cell under the beam.

Parameters:
- X0, 192: left pixel edge of the text window.
- Y0, 208: top pixel edge of the text window.
- COLS, 32: cells per row; must be a power of two. Cells are 8 px wide.
- ROWS, 4: rows in the window; must be a power of two. Cells are 16 px tall.
- BLANK, 8'h20: fill code written by every clear and by backspace.

Ports:
- clk  in  1  pixel-domain clock (25 MHz).
- rst_n  in  1  synchronous, active-low reset.
- char_in  in  8  incoming byte.
- char_valid  in  1  `char_in` is valid.
- char_ready  out  1  buffer can accept a byte this cycle.
- x  in  10  current pixel column.
- y  in  10  current pixel row.
- ascii_code  out  8  glyph code for the cell under (x, y); registered.
- cursor_col  out  log2(COLS)  current cursor column.
- cursor_row  out  log2(ROWS)  current cursor row.
- busy  out  1  a clear sequence is in progress.

Behaviour:
- Reset and sampling:
  - Single clock. Reset is synchronous and active-low; all state is sampled on the rising edge of `clk` while `rst_n`=0.
  - Reset values: `ascii_code`=8'h00, `char_ready`=0, `busy`=1, `cursor_col`=0, `cursor_row`=0, FSM=INIT.
- FSM states: INIT, IDLE, CLR_ROW, CLR_ALL.
  - INIT: writes BLANK to cells 0..COLS*ROWS-1, one cell per cycle (128 cycles at defaults), then goes to IDLE.
  - IDLE: `char_ready`=1, `busy`=0. A byte is accepted on an edge where `char_valid` and `char_ready` are both 1.
  - CLR_ROW: writes BLANK to col 0..COLS-1 of `cursor_row` (32 cycles), then goes to IDLE.
  - CLR_ALL: same sweep as INIT, then goes to IDLE with the cursor at (0,0).
  - In INIT, CLR_ROW and CLR_ALL: `char_ready`=0 and `busy`=1. `char_ready` rises on the cycle after the last clear write.
- Decode of an accepted byte in IDLE:
  - Printable (bit7=1, or 8'h20..8'h7E):
    - Write `mem[row*COLS+col]` = `char_in`.
    - If col < COLS-1: col = col+1.
    - Else: col = 0, row = (row+1) mod ROWS, go to CLR_ROW.
  - 8'h0D or 8'h0A: col = 0, row = (row+1) mod ROWS, go to CLR_ROW. This holds even if the cursor is already at col 0.
  - 8'h08 (backspace):
    - If col > 0: col = col-1, then write BLANK at the new position.
    - Else if row > 0: row = row-1, col = COLS-1, then write BLANK there.
    - Else (at 0,0): no change.
  - 8'h0C: go to CLR_ALL; cursor resets to (0,0) on entry.
  - Any other byte with bit7=0 (8'h00..8'h1F excluding the above, and 8'h7F): the handshake completes, but the byte is discarded with no state change.
  - Each accepted byte is processed in exactly one cycle. Back-to-back printable bytes are accepted every cycle until a row wrap occurs.
- Wrap-around: the row after ROWS-1 is 0. That row is cleared before further input is taken; old text is not scrolled.
- Read port:
  - Independent of the FSM and valid in every state, including during clears; partially cleared content is shown.
  - Lookup: col = (x-X0)>>3, row = (y-Y0)>>4.
  - If X0 <= x < X0+8*COLS and Y0 <= y < Y0+16*ROWS: `ascii_code` = mem[row*COLS+col] one cycle after x,y are presented.
  - Otherwise `ascii_code` = 8'h00 after the same one-cycle latency.
- Write and read in the same cycle to the same cell: the read returns the old value (read-first).
- Reset asserted mid-clear or mid-write: the sequence aborts and INIT restarts. The byte presented in that cycle is not accepted.
- Arithmetic:
  - Cell address is {row, col}, log2(COLS*ROWS) bits.
  - x-X0 and y-Y0 are computed at 10 bits; the range check precedes the use of col/row.

Test Plan:
- Reset held 3 cycles, then released: `char_ready`=0 and `busy`=1 for exactly 128 cycles; then `char_ready`=1. A read at x=192, y=208 gives 8'h20.
- Send "AB" (8'h41, 8'h42) back-to-back: `cursor_col`=2. Read at x=192,y=208 gives 8'h41 one cycle later; read at x=200,y=210 gives 8'h42.
- Send 32 × 8'hA1 starting at (0,0): on the 32nd byte, `cursor_col`=0 and `cursor_row`=1, `char_ready` is low for 32 cycles, and row 1 reads 8'h20. Read at x=447,y=223 gives 8'hA1.
- Backspace cases:
  - At (0,0): no change.
  - At (0,1) after filling row 0: cursor moves to (31,0) and cell (31,0) reads 8'h20.
- Newline at row 3: `cursor_row` wraps to 0, row 0 is cleared (32 busy cycles), and rows 1–3 are unchanged.
- 8'h0C mid-text: 128 busy cycles, all cells 8'h20, cursor (0,0). In addition:
  - 8'h07 is accepted and ignored.
  - A read at x=100,y=100 gives 8'h00.
  - `rst_n`=0 asserted during CLR_ALL restarts INIT.
